// File: rtl/instr_mem_ctrl_if.sv
// Fetch and loader bus between the core fetch unit / program loader and instr_mem_ctrl.
// The memory side uses the slave modport; the requester/loader side uses master.
interface instr_mem_ctrl_if #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int RAM_DEPTH = 2048
);
    localparam int WADDR_W = $clog2(RAM_DEPTH);

    logic [ADDR_W-1:0]   addr_i;
    logic                req_i;
    logic                gnt_o;
    logic                rvalid_o;
    logic [DATA_W-1:0]   rdata_o;
    logic                err_o;
    logic                write_i;
    logic [WADDR_W-1:0]  waddr_i;
    logic [DATA_W-1:0]   wdata_i;
    logic [DATA_W/8-1:0] wbe_i;
    logic                wlock_i;
    logic                wr_err_o;

    modport slave (
        input  addr_i, req_i, write_i, waddr_i, wdata_i, wbe_i, wlock_i,
        output gnt_o, rvalid_o, rdata_o, err_o, wr_err_o
    );

    modport master (
        output addr_i, req_i, write_i, waddr_i, wdata_i, wbe_i, wlock_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, wr_err_o
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: combinational boot ROM (lower half of fetch space) plus a
// byte-writable single-port RAM (upper half) behind a req/gnt/rvalid fetch port.

// Boot ROM. Word i holds h = (i * 0x9E3779B1) ^ 0x5A5A0F0F; byte b of a word is
// byte (b % 4) of h xored with (b / 4), so wider words stay distinct per lane.
module rom #(
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 11
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] data
);
    localparam int SLOTS = 1 << IDX_W;

    function automatic logic [DATA_W-1:0] rom_word(input int unsigned i);
        logic [31:0]       h;
        logic [DATA_W-1:0] w;
        h = (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        w = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            w[b*8 +: 8] = h[(b % 4) * 8 +: 8] ^ 8'(b / 4);
        end
        return w;
    endfunction

    logic [DATA_W-1:0] rom_table [SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_word
            if (gi < DEPTH) begin : g_used
                assign rom_table[gi] = rom_word(gi);
            end else begin : g_pad
                assign rom_table[gi] = '0;
            end
        end
    endgenerate

    assign data = rom_table[idx];
endmodule

module instr_mem_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int RAM_DEPTH = 2048,
    parameter int ROM_DEPTH = 2048,
    parameter int LATENCY   = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    instr_mem_ctrl_if.slave bus
);
    localparam int IDX_W  = ADDR_W - 1;
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int NB     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_DEPTH);

    logic [IDX_W-1:0]  idx;
    logic              is_ram;
    logic              in_range;
    logic              wr_eff;
    logic              gnt;
    logic              accept;
    logic              ram_rd;
    logic [RAM_AW-1:0] ram_idx;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] ram_q;

    assign idx      = bus.addr_i[IDX_W-1:0];
    assign is_ram   = bus.addr_i[ADDR_W-1];
    assign in_range = is_ram ? ({1'b0, idx} < RAM_LIMIT) : ({1'b0, idx} < ROM_LIMIT);
    assign ram_idx  = idx[RAM_AW-1:0];

    // The loader owns the single RAM port; only RAM fetches are stalled by it.
    assign wr_eff    = bus.write_i & ~bus.wlock_i & ~rst_i;
    assign gnt       = ~(wr_eff & is_ram);
    assign bus.gnt_o = gnt;
    assign accept    = bus.req_i & gnt & ~rst_i;
    assign ram_rd    = accept & is_ram & in_range;

    rom #(
        .DEPTH  (ROM_DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (ROM_AW)
    ) u_rom (
        .idx  (idx[ROM_AW-1:0]),
        .data (rom_data)
    );

    // One 8-bit memory per byte lane so each lane maps onto a plain block RAM
    // with its own write enable and a registered read port.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [RAM_DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge clk_i) begin
                if (wr_eff && bus.wbe_i[gi]) begin
                    lane_mem[bus.waddr_i] <= bus.wdata_i[gi*8 +: 8];
                end
                if (ram_rd) begin
                    lane_q <= lane_mem[ram_idx];
                end
            end

            assign ram_q[gi*8 +: 8] = lane_q;
        end
    endgenerate

    logic              s1_valid_reg;
    logic              s1_err_reg;
    logic              s1_ram_reg;
    logic [DATA_W-1:0] rom_q_reg;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_ram_reg   <= 1'b0;
            rom_q_reg    <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_err_reg <= ~in_range;
                s1_ram_reg <= is_ram;
                if (!is_ram && in_range) begin
                    rom_q_reg <= rom_data;
                end
            end
        end
    end

    // Source registers only move on an accept, so this mux holds the last response.
    assign s1_data = s1_err_reg ? '0 : (s1_ram_reg ? ram_q : rom_q_reg);

    generate
        if (LATENCY == 2) begin : g_lat2
            logic              rvalid_reg;
            logic [DATA_W-1:0] rdata_reg;
            logic              err_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                    err_reg    <= 1'b0;
                end else begin
                    rvalid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        rdata_reg <= s1_data;
                        err_reg   <= s1_err_reg;
                    end
                end
            end

            assign bus.rvalid_o = rvalid_reg;
            assign bus.rdata_o  = rdata_reg;
            assign bus.err_o    = err_reg;
        end else begin : g_lat1
            assign bus.rvalid_o = s1_valid_reg;
            assign bus.rdata_o  = s1_data;
            assign bus.err_o    = s1_err_reg;
        end
    endgenerate

    logic wr_err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_err_reg <= 1'b0;
        end else if (bus.write_i && bus.wlock_i) begin
            wr_err_reg <= 1'b1;
        end
    end

    assign bus.wr_err_o = wr_err_reg;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: one LATENCY=1 and one LATENCY=2 instance driven in lockstep,
// checked by a directed vector table, hand sequences and a random scoreboard run.
module tb_instr_mem_ctrl;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 2048;
    localparam int ROM_DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        write;
    logic        wlock;
    logic        req;
    logic [11:0] addr;
    logic [10:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;

    instr_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH)) bus1 ();
    instr_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH)) bus2 ();

    assign bus1.addr_i = addr;  assign bus2.addr_i = addr;
    assign bus1.req_i = req;    assign bus2.req_i = req;
    assign bus1.write_i = write; assign bus2.write_i = write;
    assign bus1.waddr_i = waddr; assign bus2.waddr_i = waddr;
    assign bus1.wdata_i = wdata; assign bus2.wdata_i = wdata;
    assign bus1.wbe_i = wbe;    assign bus2.wbe_i = wbe;
    assign bus1.wlock_i = wlock; assign bus2.wlock_i = wlock;

    instr_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH),
                     .ROM_DEPTH(ROM_DEPTH), .LATENCY(1)) dut1 (
        .clk_i (clk), .rst_i (rst), .bus (bus1));
    instr_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH),
                     .ROM_DEPTH(ROM_DEPTH), .LATENCY(2)) dut2 (
        .clk_i (clk), .rst_i (rst), .bus (bus2));

    logic        rv [2];
    logic [31:0] rd [2];
    logic        er [2];
    logic        gn [2];
    logic        we [2];
    assign rv[0] = bus1.rvalid_o; assign rv[1] = bus2.rvalid_o;
    assign rd[0] = bus1.rdata_o;  assign rd[1] = bus2.rdata_o;
    assign er[0] = bus1.err_o;    assign er[1] = bus2.err_o;
    assign gn[0] = bus1.gnt_o;    assign gn[1] = bus2.gnt_o;
    assign we[0] = bus1.wr_err_o; assign we[1] = bus2.wr_err_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Boot ROM contents as documented for the rom submodule.
    function automatic logic [31:0] rom_ref(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] preload(input int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       expq [2][$];
    logic [31:0] ram_m [RAM_DEPTH];
    logic [31:0] last_d [2];
    logic        last_e [2];
    logic        wr_err_m;
    int          cyc;

    function automatic resp_t fetch_ref(input logic [11:0] a, input int due);
        resp_t r;
        int    i;
        i = int'(a[10:0]);
        r.due = due;
        if (a[11]) begin
            r.data = ram_m[i];
            r.err  = 1'b0;
        end else if (i >= ROM_DEPTH) begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end else begin
            r.data = rom_ref(i);
            r.err  = 1'b0;
        end
        return r;
    endfunction

    initial begin
        cyc = 0;
        wr_err_m = 1'b0;
        for (int d = 0; d < 2; d++) begin
            last_d[d] = 32'h0;
            last_e[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    expq[d].delete();
                    last_d[d] = 32'h0;
                    last_e[d] = 1'b0;
                end
                wr_err_m = 1'b0;
            end else begin
                if (req && !(write && !wlock && addr[11])) begin
                    expq[0].push_back(fetch_ref(addr, cyc + 1));
                    expq[1].push_back(fetch_ref(addr, cyc + 2));
                end
                if (write && !wlock) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbe[b]) ram_m[waddr][b*8 +: 8] = wdata[b*8 +: 8];
                    end
                end
                if (write && wlock) wr_err_m = 1'b1;
            end
            cyc++;
        end
    end

    initial begin
        resp_t r;
        logic  exp_v;
        logic  exp_g;
        forever begin
            @(negedge clk);
            exp_g = !(write && !wlock && !rst && addr[11]);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("sb_gnt[%0d]", d), gn[d], exp_g);
                exp_v = (expq[d].size() > 0) && (expq[d][0].due == cyc);
                chk($sformatf("sb_rvalid[%0d]", d), rv[d], exp_v);
                if (exp_v) begin
                    r = expq[d].pop_front();
                    chk($sformatf("sb_rdata[%0d]", d), rd[d], r.data);
                    chk($sformatf("sb_err[%0d]", d), er[d], r.err);
                    last_d[d] = r.data;
                    last_e[d] = r.err;
                end else if (!rv[d]) begin
                    chk($sformatf("sb_rdata_hold[%0d]", d), rd[d], last_d[d]);
                    chk($sformatf("sb_err_hold[%0d]", d), er[d], last_e[d]);
                end
                chk($sformatf("sb_wr_err[%0d]", d), we[d], wr_err_m);
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        w;
        logic        l;
        logic [10:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rq;
        logic [11:0] a;
        logic        g;
        logic        v;
        logic [31:0] d;
        logic        e;
        logic        werr;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic l, input logic [10:0] wa,
                                input logic [31:0] wd, input logic [3:0] be, input logic rq,
                                input logic [11:0] a, input logic g, input logic v,
                                input logic [31:0] d, input logic e, input logic werr);
        vec_t x;
        x.w = w; x.l = l; x.wa = wa; x.wd = wd; x.be = be; x.rq = rq; x.a = a;
        x.g = g; x.v = v; x.d = d; x.e = e; x.werr = werr;
        return x;
    endfunction

    task automatic idle_inputs();
        write = 1'b0; wlock = 1'b0; req = 1'b0; addr = '0;
        waddr = '0; wdata = '0; wbe = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h005, 1,1,rom_ref(5),    0,0));
        vecs.push_back(mk(1,0,11'h010,32'hAABBCCDD,4'hF, 0,12'h000, 1,0,rom_ref(5),    0,0));
        vecs.push_back(mk(1,0,11'h010,32'h11223344,4'h5, 0,12'h000, 1,0,rom_ref(5),    0,0));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h810, 1,1,32'hAA22CC44,  0,0));
        vecs.push_back(mk(1,0,11'h011,32'h01020304,4'hF, 1,12'h810, 0,0,32'hAA22CC44,  0,0));
        vecs.push_back(mk(1,0,11'h012,32'h0A0B0C0D,4'hF, 1,12'h003, 1,1,rom_ref(3),    0,0));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h810, 1,1,32'hAA22CC44,  0,0));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h811, 1,1,32'h01020304,  0,0));
        vecs.push_back(mk(1,1,11'h020,32'hDEADBEEF,4'hF, 0,12'h000, 1,0,32'h01020304,  0,1));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h820, 1,1,preload(32'h20),0,1));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h400, 1,1,32'h0,         1,1));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h3FF, 1,1,rom_ref(12'h3FF),0,1));
        vecs.push_back(mk(1,0,11'h010,32'hFFFFFFFF,4'h0, 1,12'h810, 0,0,rom_ref(12'h3FF),0,1));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        1,12'h810, 1,1,32'hAA22CC44,  0,1));
        vecs.push_back(mk(0,0,11'h000,32'h0,4'h0,        0,12'h000, 1,0,32'hAA22CC44,  0,1));

        rst = 1'b1;
        idle_inputs();
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_rvalid[%0d]", d), rv[d], 1'b0);
            chk($sformatf("reset_rdata[%0d]", d), rd[d], 32'h0);
            chk($sformatf("reset_err[%0d]", d), er[d], 1'b0);
            chk($sformatf("reset_wr_err[%0d]", d), we[d], 1'b0);
        end
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            write = 1'b1; waddr = 11'(i); wdata = preload(i); wbe = 4'hF;
            step();
        end
        idle_inputs();
        step();

        foreach (vecs[k]) begin
            write = vecs[k].w; wlock = vecs[k].l; waddr = vecs[k].wa;
            wdata = vecs[k].wd; wbe = vecs[k].be; req = vecs[k].rq; addr = vecs[k].a;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", k), gn[0], vecs[k].g);
            step();
            chk($sformatf("vec%0d_rvalid", k), rv[0], vecs[k].v);
            chk($sformatf("vec%0d_rdata", k), rd[0], vecs[k].d);
            chk($sformatf("vec%0d_err", k), er[0], vecs[k].e);
            chk($sformatf("vec%0d_wr_err", k), we[0], vecs[k].werr);
            idle_inputs();
        end

        // Back-to-back fetches through the two-stage instance.
        req = 1'b1; addr = 12'h800;
        step();
        chk("pipe_l1_rdata0", rd[0], preload(0));
        chk("pipe_l2_early", rv[1], 1'b0);
        addr = 12'h801;
        step();
        chk("pipe_l2_rvalid0", rv[1], 1'b1);
        chk("pipe_l2_rdata0", rd[1], preload(0));
        addr = 12'h802;
        step();
        chk("pipe_l2_rvalid1", rv[1], 1'b1);
        chk("pipe_l2_rdata1", rd[1], preload(1));
        req = 1'b0;
        step();
        chk("pipe_l2_rvalid2", rv[1], 1'b1);
        chk("pipe_l2_rdata2", rd[1], preload(2));
        step();
        chk("pipe_l2_idle", rv[1], 1'b0);

        // Reset one cycle after an accept; writes and fetches during reset.
        req = 1'b1; addr = 12'h805;
        step();
        req = 1'b0; rst = 1'b1;
        step();
        write = 1'b1; waddr = 11'h005; wdata = 32'h0; wbe = 4'hF;
        req = 1'b1; addr = 12'h806;
        @(negedge clk);
        chk("rst_gnt_ram", gn[0], 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("inrst_rvalid[%0d]", d), rv[d], 1'b0);
            chk($sformatf("inrst_rdata[%0d]", d), rd[d], 32'h0);
            chk($sformatf("inrst_err[%0d]", d), er[d], 1'b0);
            chk($sformatf("inrst_wr_err[%0d]", d), we[d], 1'b0);
        end
        step();
        idle_inputs();
        rst = 1'b0;
        repeat (2) begin
            step();
            chk("post_rst_rvalid_l1", rv[0], 1'b0);
            chk("post_rst_rvalid_l2", rv[1], 1'b0);
        end
        req = 1'b1; addr = 12'h805;
        step();
        req = 1'b0;
        chk("rst_no_write_l1", rd[0], preload(5));

        // Random traffic against the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            write = ($urandom_range(0, 2) == 0);
            wlock = ($urandom_range(0, 7) == 0);
            waddr = 11'($urandom_range(0, 63));
            wdata = $urandom;
            wbe   = 4'($urandom);
            req   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) addr = {1'b1, 11'($urandom_range(0, 63))};
            else                           addr = 12'($urandom_range(0, 2047));
            step();
        end
        idle_inputs();
        rst = 1'b0;
        repeat (5) step();
        chk("drain_l1", expq[0].size(), 0);
        chk("drain_l2", expq[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory for the core's fetch port: a combinational boot ROM in the lower half of the fetch address space and a byte-writable RAM in the upper half, served over the req/gnt/rvalid fetch handshake. Adds configurable read latency, address-range error responses, loader byte enables, a loader write lock, and a sticky write-error flag. Sits on the bus between the core fetch unit and the program loader.

## Interface
- ADDR_W, 12, fetch word-address width; MSB selects region (0 = ROM, 1 = RAM)
- DATA_W, 32, word width; multiple of 8
- RAM_DEPTH, 2048, RAM words; must be ≤ 2^(ADDR_W-1)
- ROM_DEPTH, 2048, ROM words implemented by the `rom` submodule; ≤ 2^(ADDR_W-1)
- LATENCY, 1, cycles from accept to rvalid_o; legal values 1 or 2
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- addr_i  in  ADDR_W  fetch word address
- req_i  in  1  fetch request
- gnt_o  out  1  fetch accepted this cycle when high with req_i
- rvalid_o  out  1  one-cycle response strobe
- rdata_o  out  DATA_W  response data
- err_o  out  1  response is an error; valid with rvalid_o
- write_i  in  1  loader write strobe
- waddr_i  in  $clog2(RAM_DEPTH)  loader RAM word index
- wdata_i  in  DATA_W  loader write data
- wbe_i  in  DATA_W/8  loader byte enables
- wlock_i  in  1  when high, loader writes are blocked
- wr_err_o  out  1  sticky: a loader write was dropped

## Operation
- Region decode: idx = addr_i[ADDR_W-2:0]; RAM if addr_i[ADDR_W-1]=1, else ROM.
- Range check: idx ≥ RAM_DEPTH (RAM) or idx ≥ ROM_DEPTH (ROM) -> error response: rdata_o = 0, err_o = 1. No memory access.
- Effective write: wr_eff = write_i & ~wlock_i & ~rst_i. On wr_eff, each byte b with wbe_i[b]=1 is written to mem[waddr_i]; other bytes are unchanged. wbe_i = 0 is a legal no-op.
- Dropped write: write_i & wlock_i -> no update, wr_err_o set to 1. It stays set until rst_i.
- Single-port RAM: gnt_o = ~(wr_eff & addr_i[ADDR_W-1]). The combinational gnt_o is independent of req_i. The loader always wins. ROM fetches are granted during loader writes.
- Accept = req_i & gnt_o. Accepts may occur every cycle. Responses are returned in order, exactly one per accept.
- Ungranted requests produce no response; the requester holds addr_i until granted.
- rdata_o and err_o hold their last response values between rvalid_o strobes.
- RAM and ROM contents are not affected by rst_i.

## Timing
- LATENCY=1: accept in cycle N -> rvalid_o, rdata_o, err_o in cycle N+1. The RAM is read at the edge ending cycle N.
- LATENCY=2: one extra output register stage. Response in N+2. Throughput remains one response per cycle.
- Write at edge ending cycle N, then RAM fetch of the same word accepted in cycle N+1 -> the response carries the new data.
- Same-cycle write plus fetch of the same RAM word cannot occur, because gnt_o=0.
- Reset values: rvalid_o=0, rdata_o=0, err_o=0, wr_err_o=0, all pipeline valid bits 0.
- rst_i mid-operation discards every in-flight response: no rvalid_o in the cycle after reset deasserts.
- Fetches presented while rst_i=1 are granted per the gnt_o rule but produce no response.
- wr_eff is forced low during reset.

## Test plan
- ROM fetch: LATENCY=1, req_i=1, addr_i=0x005 in cycle N -> rvalid_o=1 in N+1, rdata_o = rom word 5, err_o=0.
- Byte-masked load and read-back: write waddr_i=0x010, wdata_i=0xAABBCCDD, wbe_i=4'b1111; then wdata_i=0x11223344, wbe_i=4'b0101. Fetch addr_i=0x810 -> rdata_o=0xAA22CC44.
- Collision: same cycle write_i=1 and req_i=1 to addr_i=0x810 -> gnt_o=0, no response. Repeat with addr_i=0x003 -> gnt_o=1, ROM data returned.
- Lock and range: wlock_i=1, write_i=1 to waddr_i=0x020 -> word unchanged, wr_err_o=1 held until rst_i. With ROM_DEPTH=1024, fetch 0x400 -> rvalid_o=1, err_o=1, rdata_o=0.
- Pipelining: LATENCY=2, back-to-back accepts at 0x800, 0x801, 0x802 in N..N+2 -> rvalid_o high N+2..N+4 with data in order.
- Reset mid-flight: assert rst_i one cycle after an accept -> no rvalid_o afterwards; all outputs 0 while in reset.
